// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake shared by the two UART requesters and the arbiter.
interface uart_tx_arbiter_if;
  logic [7:0] req0_data;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_valid;
  logic       req1_ready;

  modport master (
    output req0_data, req0_valid, req1_data, req1_valid,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_data, req0_valid, req1_data, req1_valid,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART 8N1 transmitter with per-byte round-robin arbitration.
// Optional UART_ARB_LINE_LOCK_EN keeps the line with one requester until it sends 0x0A.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             resetb,
  uart_tx_arbiter_if.slave req,
  output logic             tx,
  output logic             busy,
  output logic             owner
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] LP_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || LOCK_TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: CLKS_PER_BIT or LOCK_TIMEOUT out of range");
  end

  state_t      r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_byte;
  logic        r_tx;
  logic        r_busy;
  logic        r_owner;

  logic        w_any;
  logic        w_sel;
  logic        w_accept;
  logic        w_baud_done;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  w_byte_in;

`ifdef UART_ARB_LINE_LOCK_EN
  localparam int               LP_LCW       = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [LP_LCW-1:0] LP_LOCK_LAST = LP_LCW'(LOCK_TIMEOUT - 1);

  logic              r_lock;
  logic [LP_LCW-1:0] r_lock_cnt;
  logic              w_owner_valid;

  assign w_owner_valid = r_owner ? req.req1_valid : req.req0_valid;
`endif

  always_comb begin
    w_any = req.req0_valid | req.req1_valid;
    w_sel = (req.req0_valid && req.req1_valid) ? ~r_owner : req.req1_valid;
`ifdef UART_ARB_LINE_LOCK_EN
    // A locked line only ever serves the current owner.
    if (r_lock) begin
      w_sel = r_owner;
      w_any = w_owner_valid;
    end
`endif
  end

  assign w_accept       = resetb && (r_state == S_IDLE) && w_any;
  assign req.req0_ready = w_accept && !w_sel;
  assign req.req1_ready = w_accept && w_sel;
  assign w_byte_in      = w_sel ? req.req1_data : req.req0_data;
  assign w_baud_done    = (r_baud == LP_BAUD_LAST);
  assign w_bit_nxt      = r_bit + 3'd1;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_owner <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_byte  <= w_byte_in;
            r_owner <= w_sel;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_state <= S_DATA;
            r_tx    <= r_byte[0];
            r_baud  <= '0;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
              r_bit   <= '0;
            end else begin
              r_bit <= w_bit_nxt;
              r_tx  <= r_byte[w_bit_nxt];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_baud  <= '0;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_ARB_LINE_LOCK_EN
  // While locked and idle without a grant, the owner's valid is necessarily low.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_lock     <= 1'b0;
      r_lock_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_lock     <= (w_byte_in != 8'h0A);
        r_lock_cnt <= '0;
      end else if (r_lock) begin
        if (r_lock_cnt == LP_LOCK_LAST) begin
          r_lock     <= 1'b0;
          r_lock_cnt <= '0;
        end else begin
          r_lock_cnt <= r_lock_cnt + 1'b1;
        end
      end
    end
  end
`endif

  assign tx    = r_tx;
  assign busy  = r_busy;
  assign owner = r_owner;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: frame-level reference model, UART decoder and directed/random scenarios.
module tb_uart_tx_arbiter;
  localparam int CPB     = 4;
  localparam int LOCK_TO = 8;

  logic clk = 1'b0;
  logic resetb;
  logic tx, busy, owner;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .clock (clk),
    .resetb(resetb),
    .req   (bus),
    .tx    (tx),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit stall_en = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] rx_q[$];
  logic [7:0] m_log[$];
  int         starts[$];

  // reference model: elapsed cycles within the current frame, -1 when idle
  int         m_el    = -1;
  logic [7:0] m_byte  = 8'h00;
  bit         m_owner = 1'b1;
  bit         m_lock  = 1'b0;
  int         m_idle_lo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int model_grant(input bit v0, input bit v1);
    if (m_lock) return ((m_owner ? v1 : v0) ? int'(m_owner) : -1);
    if (v0 && v1) return m_owner ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // requester drivers: hold the queue head valid (optionally with random stalls)
  initial begin
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_data  = 8'h00; bus.req1_data  = 8'h00;
  end

  always begin : drv
    bit hs0, hs1;
    @(negedge clk);
    hs0 = bus.req0_valid && bus.req0_ready;
    hs1 = bus.req1_valid && bus.req1_ready;
    @(posedge clk);
    #1;
    if (hs0 && q0.size() > 0) void'(q0.pop_front());
    if (hs1 && q1.size() > 0) void'(q1.pop_front());
    bus.req0_valid = (q0.size() > 0) && (!stall_en || $urandom_range(0, 3) != 0);
    bus.req1_valid = (q1.size() > 0) && (!stall_en || $urandom_range(0, 3) != 0);
    bus.req0_data  = (q0.size() > 0) ? q0[0] : 8'($urandom);
    bus.req1_data  = (q1.size() > 0) ? q1[0] : 8'($urandom);
  end

  // model compare and advance; inputs are stable from negedge to the next posedge
  always @(negedge clk) begin : mdl
    int   g;
    int   idx;
    logic etx;
    etx = 1'b1;
    if (m_el >= 0) begin
      idx = m_el / CPB;
      etx = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : m_byte[idx-1];
    end
    g = (m_el < 0 && resetb) ? model_grant(bus.req0_valid, bus.req1_valid) : -1;
    chk("cyc_tx", tx, etx);
    chk("cyc_busy", busy, (m_el >= 0));
    chk("cyc_owner", owner, m_owner);
    chk("cyc_ready0", bus.req0_ready, (g == 0));
    chk("cyc_ready1", bus.req1_ready, (g == 1));
    if (!resetb) begin
      m_el = -1; m_owner = 1'b1; m_lock = 1'b0; m_idle_lo = 0;
    end else if (m_el >= 0) begin
      m_el++;
      if (m_el == 10 * CPB) m_el = -1;
    end else if (g >= 0) begin
      m_byte  = (g == 1) ? bus.req1_data : bus.req0_data;
      m_owner = (g == 1);
      m_el    = 0;
      m_log.push_back(m_byte);
`ifdef UART_ARB_LINE_LOCK_EN
      m_lock    = (m_byte != 8'h0A);
      m_idle_lo = 0;
`endif
    end else if (m_lock) begin
      m_idle_lo++;
      if (m_idle_lo == LOCK_TO) begin
        m_lock = 1'b0; m_idle_lo = 0;
      end
    end
  end

  // independent UART receiver sampling mid-bit, plus frame-start monitor
  always @(negedge clk) begin : rxd
    bit         act;
    int         cnt;
    logic [7:0] b;
    bit         prev_busy;
    if (busy === 1'b1 && !prev_busy) starts.push_back(cyc);
    prev_busy = (busy === 1'b1);
    if (!resetb) begin
      act = 1'b0;
    end else if (!act) begin
      if (tx === 1'b0) begin act = 1'b1; cnt = 0; end
    end else begin
      cnt++;
      for (int k = 0; k < 8; k++)
        if (cnt == CPB * (k + 1) + CPB / 2) b[k] = tx;
      if (cnt == 9 * CPB + CPB / 2) begin
        chk("rx_stop_bit", tx, 1'b1);
        rx_q.push_back(b);
        act = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    resetb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_q.delete(); starts.delete(); m_log.delete();
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    resetb = 1'b1;
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b1) return;
    end
    n_tests++; n_fail++;
    $display("FAIL wait_busy: timeout after %0d cycles, required busy=1", budget);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && busy === 1'b0) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL wait_drain: timeout after %0d cycles, q0=%0d q1=%0d", budget, q0.size(), q1.size());
  endtask

  task automatic chk_seq(input string nm, input logic [7:0] e[$]);
    chk({nm, "_len"}, rx_q.size(), e.size());
    for (int i = 0; i < e.size() && i < rx_q.size(); i++) chk(nm, rx_q[i], e[i]);
  endtask

  initial begin : wdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] e[$];
    logic [39:0] v;
    resetb = 1'b0;
    q0.push_back(8'h37);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_seen", bus.req0_valid, 1'b1);
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b1);
    release_reset();

    // single 0x37 frame, waveform pinned literally
    wait_busy(20);
    for (int i = 0; i < 40; i++) begin
      v[i] = tx;
      chk("f37_busy", busy, 1'b1);
      @(negedge clk);
    end
    chk("f37_wave", v, 40'hF00FF0FFF0);
    chk("f37_busy_end", busy, 1'b0);
    chk("f37_owner", owner, 1'b0);
    wait_drain(100);
    e = {8'h37};
    chk_seq("f37_rx", e);

    // both valid, held: alternate starting with requester 0
    do_reset();
    for (int i = 0; i < 3; i++) begin q0.push_back(8'h41); q1.push_back(8'h42); end
    release_reset();
    wait_drain(400);
    e = {8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h42};
    chk_seq("rr_rx", e);
    chk("rr_starts", starts.size(), 6);
    for (int i = 1; i < starts.size(); i++) chk("rr_spacing", starts[i] - starts[i-1], 41);

    // reset in the middle of a frame
    do_reset();
    q0.push_back(8'h33);
    release_reset();
    wait_busy(20);
    repeat (14) @(negedge clk);
    @(posedge clk); #1;
    resetb = 1'b0;
    @(posedge clk); #1;
    resetb = 1'b1;
    q1.push_back(8'h55);
    @(negedge clk);
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_no_rx", rx_q.size(), 0);
    wait_drain(200);
    e = {8'h55};
    chk_seq("abort_rx", e);
    chk("abort_owner", owner, 1'b1);

    // "AB\n" from requester 0 against 0x5A from requester 1
    do_reset();
    q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h0A);
`ifdef UART_ARB_LINE_LOCK_EN
    q1.push_back(8'h5A);
    release_reset();
    wait_drain(400);
    e = {8'h41, 8'h42, 8'h0A, 8'h5A};
    chk_seq("lock_rx", e);

    do_reset();
    q0.push_back(8'h41);
    q1.push_back(8'h5A);
    release_reset();
    wait_drain(400);
    e = {8'h41, 8'h5A};
    chk_seq("timeout_rx", e);
    chk("timeout_starts", starts.size(), 2);
    if (starts.size() == 2) chk("timeout_spacing", starts[1] - starts[0], 10 * CPB + LOCK_TO + 1);
`else
    q1.push_back(8'h5A); q1.push_back(8'h5A);
    release_reset();
    wait_drain(400);
    e = {8'h41, 8'h5A, 8'h42, 8'h5A, 8'h0A};
    chk_seq("nolock_rx", e);
`endif

    // randomized traffic with random valid stalls
    do_reset();
    for (int i = 0; i < 24; i++) begin
`ifdef UART_ARB_LINE_LOCK_EN
      q0.push_back(($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom));
      q1.push_back(($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom));
`else
      q0.push_back(8'($urandom));
      q1.push_back(8'($urandom));
`endif
    end
    stall_en = 1'b1;
    release_reset();
    wait_drain(8000);
    stall_en = 1'b0;
    chk("rand_accepted", m_log.size(), 48);
    chk_seq("rand_rx", m_log);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
